// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - rx bytes -> bit-reversed sample RAM frame -> FFT -> byte-serial tx of results
// Optional build macro: FRAME_HDR_EN (prefixes each result stream with a 4-byte header)
module fft_frame_sequencer #(
    parameter int N_LOG2  = 5,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        fifo_data_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_o,
    output logic              ram_we_o,
    output logic [N_LOG2-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
    output logic              fft_start_o,
    input  logic              fft_done_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam logic [N_LOG2-1:0] K_LAST  = '1;
    localparam logic [15:0]       TO_LAST = 16'(TIMEOUT - 1);
`ifdef FRAME_HDR_EN
    localparam logic [15:0]       PAYLOAD_LEN = 16'(4 * (1 << N_LOG2));
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_FFT,
        RD_ISSUE,
        RD_LATCH,
        TX_BYTE
`ifdef FRAME_HDR_EN
        , TX_HDR
`endif
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          b_q;
    logic [N_LOG2-1:0]   k_q;
    logic [23:0]         asm_q;
    logic [15:0]         tcnt_q;
    logic [31:0]         shreg_q;
    logic                err_q;
    logic                we_q;
    logic [N_LOG2-1:0]   addr_q;
    logic [31:0]         wdata_q;

    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
        logic [N_LOG2-1:0] r;
        for (int i = 0; i < N_LOG2; i++) begin
            r[i] = v[N_LOG2-1-i];
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        fifo_rd_o   = 1'b0;
        fft_start_o = 1'b0;
        tx_valid_o  = 1'b0;
        tx_data_o   = 8'h00;
        case (state)
            IDLE: begin
                if (!fifo_empty_i) state_nxt = LOAD;
            end
            LOAD: begin
                fifo_rd_o = !fifo_empty_i;
                if (!fifo_empty_i && b_q == 2'd3 && k_q == K_LAST) state_nxt = START;
            end
            START: begin
                fft_start_o = 1'b1;
                state_nxt   = WAIT_FFT;
            end
            WAIT_FFT: begin
                if (fft_done_i) begin
`ifdef FRAME_HDR_EN
                    state_nxt = TX_HDR;
`else
                    state_nxt = RD_ISSUE;
`endif
                end else if (tcnt_q == TO_LAST) begin
                    state_nxt = IDLE;
                end
            end
            RD_ISSUE: state_nxt = RD_LATCH;
            RD_LATCH: state_nxt = TX_BYTE;
            TX_BYTE: begin
                tx_valid_o = 1'b1;
                tx_data_o  = shreg_q[{b_q, 3'b000} +: 8];
                if (tx_ready_i && b_q == 2'd3) state_nxt = (k_q == K_LAST) ? IDLE : RD_ISSUE;
            end
`ifdef FRAME_HDR_EN
            TX_HDR: begin
                tx_valid_o = 1'b1;
                case (b_q)
                    2'd0:    tx_data_o = 8'hA5;
                    2'd1:    tx_data_o = 8'h5A;
                    2'd2:    tx_data_o = PAYLOAD_LEN[7:0];
                    default: tx_data_o = PAYLOAD_LEN[15:8];
                endcase
                if (tx_ready_i && b_q == 2'd3) state_nxt = RD_ISSUE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Read address is presented combinationally so the RAM's 1-cycle latency lands in RD_LATCH.
    assign ram_addr_o  = (state == RD_ISSUE) ? k_q : addr_q;
    assign ram_we_o    = we_q;
    assign ram_wdata_o = wdata_q;
    assign busy_o      = (state != IDLE);
    assign err_o       = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_q     <= 2'd0;
            k_q     <= '0;
            asm_q   <= 24'd0;
            tcnt_q  <= 16'd0;
            shreg_q <= 32'd0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            we_q <= 1'b0;
            if (fifo_rd_o) err_q <= 1'b0;
            case (state)
                IDLE: begin
                    b_q <= 2'd0;
                    k_q <= '0;
                end
                LOAD: begin
                    if (fifo_rd_o) begin
                        b_q <= b_q + 2'd1;
                        case (b_q)
                            2'd0: asm_q[7:0]   <= fifo_data_i;
                            2'd1: asm_q[15:8]  <= fifo_data_i;
                            2'd2: asm_q[23:16] <= fifo_data_i;
                            default: begin
                                we_q    <= 1'b1;
                                addr_q  <= bitrev(k_q);
                                wdata_q <= {fifo_data_i, asm_q};
                                k_q     <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
                            end
                        endcase
                    end
                end
                START: tcnt_q <= 16'd0;
                WAIT_FFT: begin
                    b_q <= 2'd0;
                    k_q <= '0;
                    if (!fft_done_i) begin
                        if (tcnt_q == TO_LAST) err_q <= 1'b1;
                        else                   tcnt_q <= tcnt_q + 16'd1;
                    end
                end
                RD_LATCH: begin
                    shreg_q <= ram_rdata_i;
                    b_q     <= 2'd0;
                end
                TX_BYTE: begin
                    if (tx_ready_i) begin
                        b_q <= b_q + 2'd1;
                        if (b_q == 2'd3 && k_q != K_LAST) k_q <= k_q + 1'b1;
                    end
                end
`ifdef FRAME_HDR_EN
                TX_HDR: begin
                    if (tx_ready_i) b_q <= b_q + 2'd1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
